// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, state encodings and command decode helper for the command sequencer.
// The RF addresses of the two ALU operand slots live here as well.
package sys_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned RF_ADDR_A = 0;
  localparam int unsigned RF_ADDR_B = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_OP_A     = 4'd5,
    ST_OP_B     = 4'd6,
    ST_ALU_FUNC = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_LO    = 4'd9,
    ST_TX_HI    = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    TXS_IDLE  = 2'd0,
    TXS_OFFER = 2'd1,
    TXS_GAP   = 2'd2
  } tx_state_t;

  // Opcode byte to first state of its command; unknown bytes leave the FSM idle.
  function automatic state_t decode_cmd(input logic [7:0] op);
    state_t st;
    case (op)
      CMD_RF_WR:   st = ST_WR_ADDR;
      CMD_RF_RD:   st = ST_RD_ADDR;
      CMD_ALU_OP:  st = ST_OP_A;
      CMD_ALU_NOP: st = ST_ALU_FUNC;
      default:     st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_sender.sv
// Streams one or two bytes of a result word to the UART transmitter, low byte first,
// holding each byte until accepted and leaving one idle cycle between bytes.
import sys_ctrl_pkg::*;

module sys_ctrl_tx_sender #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   word,
  input  logic                      two_bytes,
  input  logic                      tx_busy,
  output logic                      tx_valid,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      lo_sent,
  output logic                      done
);

  tx_state_t             state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] hi_byte_r, hi_byte_nxt_s;
  logic                  last_r, last_nxt_s;
  logic                  tx_valid_nxt_s;
  logic [DATA_WIDTH-1:0] tx_data_nxt_s;
  logic                  accept_s;

  assign accept_s = (state_r == TXS_OFFER) && !tx_busy;
  assign lo_sent  = accept_s && !last_r;
  assign done     = accept_s && last_r;

  // Next-state and next-output logic for the byte handshake.
  always_comb begin
    state_nxt_s    = state_r;
    hi_byte_nxt_s  = hi_byte_r;
    last_nxt_s     = last_r;
    tx_valid_nxt_s = tx_valid;
    tx_data_nxt_s  = tx_data;
    case (state_r)
      TXS_IDLE: begin
        if (start) begin
          state_nxt_s    = TXS_OFFER;
          tx_valid_nxt_s = 1'b1;
          tx_data_nxt_s  = word[DATA_WIDTH-1:0];
          hi_byte_nxt_s  = word[2*DATA_WIDTH-1:DATA_WIDTH];
          last_nxt_s     = !two_bytes;
        end else begin
          state_nxt_s = TXS_IDLE;
        end
      end
      TXS_OFFER: begin
        if (!tx_busy) begin
          tx_valid_nxt_s = 1'b0;
          state_nxt_s    = last_r ? TXS_IDLE : TXS_GAP;
        end else begin
          state_nxt_s = TXS_OFFER;
        end
      end
      TXS_GAP: begin
        state_nxt_s    = TXS_OFFER;
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = hi_byte_r;
        last_nxt_s     = 1'b1;
      end
      default: begin
        state_nxt_s    = TXS_IDLE;
        tx_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered TX outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= TXS_IDLE;
      hi_byte_r <= {DATA_WIDTH{1'b0}};
      last_r    <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      hi_byte_r <= hi_byte_nxt_s;
      last_r    <= last_nxt_s;
      tx_valid  <= tx_valid_nxt_s;
      tx_data   <= tx_data_nxt_s;
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes UART byte commands into register-file writes/reads and ALU runs,
// and hands read data or ALU results to the TX sender.
import sys_ctrl_pkg::*;

module sys_ctrl #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  input  logic [2*DATA_WIDTH-1:0]   alu_result,
  input  logic                      alu_result_valid,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data,
  input  logic                      rf_rd_valid,
  input  logic                      tx_busy,
  output logic                      alu_enable,
  output logic [3:0]                alu_function,
  output logic [ADDR_WIDTH-1:0]     rf_addr,
  output logic                      rf_wr_en,
  output logic                      rf_rd_en,
  output logic [DATA_WIDTH-1:0]     rf_wr_data,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_valid
);

  localparam int RW = 2 * DATA_WIDTH;

  state_t                state_r, state_nxt_s;
  logic                  start_pending_r, start_pending_nxt_s;
  logic [RW-1:0]         result_r, result_nxt_s;
  logic                  alu_enable_nxt_s;
  logic [3:0]            alu_function_nxt_s;
  logic [ADDR_WIDTH-1:0] rf_addr_nxt_s;
  logic                  rf_wr_en_nxt_s;
  logic                  rf_rd_en_nxt_s;
  logic [DATA_WIDTH-1:0] rf_wr_data_nxt_s;
  logic                  tx_start_s;
  logic                  tx_two_s;
  logic                  tx_lo_sent_s;
  logic                  tx_done_s;

  // Command decode and sequencing; every strobe defaults low so it lasts one cycle.
  always_comb begin
    state_nxt_s         = state_r;
    start_pending_nxt_s = start_pending_r;
    result_nxt_s        = result_r;
    alu_enable_nxt_s    = 1'b0;
    alu_function_nxt_s  = alu_function;
    rf_addr_nxt_s       = rf_addr;
    rf_wr_en_nxt_s      = 1'b0;
    rf_rd_en_nxt_s      = 1'b0;
    rf_wr_data_nxt_s    = rf_wr_data;
    tx_start_s          = 1'b0;
    tx_two_s            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) begin
          state_nxt_s = decode_cmd(rx_data[7:0]);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (rx_valid) begin
          rf_addr_nxt_s = rx_data[ADDR_WIDTH-1:0];
          state_nxt_s   = ST_WR_DATA;
        end else begin
          state_nxt_s = ST_WR_ADDR;
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          rf_wr_data_nxt_s = rx_data;
          rf_wr_en_nxt_s   = 1'b1;
          state_nxt_s      = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_DATA;
        end
      end
      ST_RD_ADDR: begin
        if (rx_valid) begin
          rf_addr_nxt_s  = rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_nxt_s = 1'b1;
          state_nxt_s    = ST_RD_WAIT;
        end else begin
          state_nxt_s = ST_RD_ADDR;
        end
      end
      ST_RD_WAIT: begin
        if (rf_rd_valid) begin
          result_nxt_s = {{DATA_WIDTH{1'b0}}, rf_rd_data};
          tx_start_s   = 1'b1;
          tx_two_s     = 1'b0;
          state_nxt_s  = ST_TX_LO;
        end else begin
          state_nxt_s = ST_RD_WAIT;
        end
      end
      ST_OP_A: begin
        if (rx_valid) begin
          rf_addr_nxt_s    = ADDR_WIDTH'(RF_ADDR_A);
          rf_wr_data_nxt_s = rx_data;
          rf_wr_en_nxt_s   = 1'b1;
          state_nxt_s      = ST_OP_B;
        end else begin
          state_nxt_s = ST_OP_A;
        end
      end
      ST_OP_B: begin
        if (rx_valid) begin
          rf_addr_nxt_s    = ADDR_WIDTH'(RF_ADDR_B);
          rf_wr_data_nxt_s = rx_data;
          rf_wr_en_nxt_s   = 1'b1;
          state_nxt_s      = ST_ALU_FUNC;
        end else begin
          state_nxt_s = ST_OP_B;
        end
      end
      ST_ALU_FUNC: begin
        if (rx_valid) begin
          alu_function_nxt_s  = rx_data[3:0];
          start_pending_nxt_s = 1'b1;
          state_nxt_s         = ST_ALU_WAIT;
        end else begin
          state_nxt_s = ST_ALU_FUNC;
        end
      end
      // The start pulse trails the opcode update by one cycle so the ALU sees a settled function.
      ST_ALU_WAIT: begin
        if (start_pending_r) begin
          alu_enable_nxt_s    = 1'b1;
          start_pending_nxt_s = 1'b0;
          state_nxt_s         = ST_ALU_WAIT;
        end else if (alu_result_valid) begin
          result_nxt_s = alu_result;
          tx_start_s   = 1'b1;
          tx_two_s     = 1'b1;
          state_nxt_s  = ST_TX_LO;
        end else begin
          state_nxt_s = ST_ALU_WAIT;
        end
      end
      ST_TX_LO: begin
        if (tx_done_s) begin
          state_nxt_s = ST_IDLE;
        end else if (tx_lo_sent_s) begin
          state_nxt_s = ST_TX_HI;
        end else begin
          state_nxt_s = ST_TX_LO;
        end
      end
      ST_TX_HI: begin
        if (tx_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TX_HI;
        end
      end
      default: begin
        state_nxt_s         = ST_IDLE;
        start_pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State, result and registered RF/ALU outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      start_pending_r <= 1'b0;
      result_r        <= {RW{1'b0}};
      alu_enable      <= 1'b0;
      alu_function    <= 4'd0;
      rf_addr         <= {ADDR_WIDTH{1'b0}};
      rf_wr_en        <= 1'b0;
      rf_rd_en        <= 1'b0;
      rf_wr_data      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r         <= state_nxt_s;
      start_pending_r <= start_pending_nxt_s;
      result_r        <= result_nxt_s;
      alu_enable      <= alu_enable_nxt_s;
      alu_function    <= alu_function_nxt_s;
      rf_addr         <= rf_addr_nxt_s;
      rf_wr_en        <= rf_wr_en_nxt_s;
      rf_rd_en        <= rf_rd_en_nxt_s;
      rf_wr_data      <= rf_wr_data_nxt_s;
    end
  end

  sys_ctrl_tx_sender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_sender (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (tx_start_s),
    .word      (result_nxt_s),
    .two_bytes (tx_two_s),
    .tx_busy   (tx_busy),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .lo_sent   (tx_lo_sent_s),
    .done      (tx_done_s)
  );

endmodule
